mem_arbiter_mc: RTL and testbench

- Parametrised multi-channel arbiter between N requesters (fetcher, load/store unit, etc.) and the byte-wide single-port RAM/IO bus.
- Serialises byte, half-word and word reads/writes into one byte per cycle, with round-robin fairness.
- Applies IO-region ordering rules and per-channel flush.
- Successor of the fixed 3-port dispatcher; sits between the core front/back end and the top-level memory interface.

---
 rtl/mem_arbiter_mc_if.sv | 37 +++
 rtl/mem_arbiter_mc.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter_mc.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_mc_if.sv
// Request and byte-bus bundle for mem_arbiter_mc. The arbiter uses the slave view;
// requesters plus the memory side use the master view.
interface mem_arbiter_mc_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                     in_rdy;
    logic                     in_flush;
    logic                     in_io_buffer_full;
    logic [7:0]               in_mem_data;
    logic [7:0]               out_mem_data;
    logic [ADDR_W-1:0]        out_mem_addr;
    logic                     out_mem_wr;
    logic [NUM_CH-1:0]        in_req_valid;
    logic [NUM_CH-1:0]        out_req_ready;
    logic [NUM_CH*ADDR_W-1:0] in_req_addr;
    logic [NUM_CH-1:0]        in_req_wr;
    logic [NUM_CH*2-1:0]      in_req_size;
    logic [NUM_CH*DATA_W-1:0] in_req_wdata;
    logic [NUM_CH-1:0]        out_resp_valid;
    logic [DATA_W-1:0]        out_resp_data;

    modport slave (
        input  in_rdy, in_flush, in_io_buffer_full, in_mem_data,
               in_req_valid, in_req_addr, in_req_wr, in_req_size, in_req_wdata,
        output out_mem_data, out_mem_addr, out_mem_wr, out_req_ready,
               out_resp_valid, out_resp_data
    );

    modport master (
        output in_rdy, in_flush, in_io_buffer_full, in_mem_data,
               in_req_valid, in_req_addr, in_req_wr, in_req_size, in_req_wdata,
        input  out_mem_data, out_mem_addr, out_mem_wr, out_req_ready,
               out_resp_valid, out_resp_data
    );
endinterface

// File: rtl/mem_arbiter_mc.sv
// Round-robin arbiter serialising multi-byte requests from NUM_CH channels onto a
// byte-wide RAM/IO bus, with IO ordering rules and per-channel flush.
module mem_arbiter_mc #(
    parameter int                NUM_CH     = 3,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                IO_SEL_LSB = 16,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = 3'b011
) (
    input logic             in_clk,
    input logic             in_rst,
    mem_arbiter_mc_if.slave bus
);
    localparam int              CH_W = $clog2(NUM_CH);
    localparam logic [CH_W:0]   N_CH = (CH_W+1)'(NUM_CH);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;
    state_t state_q, state_d;

    logic [NUM_CH-1:0]   pending, pend_d, accept, eligible;
    logic [ADDR_W-1:0]   slot_addr  [NUM_CH];
    logic [DATA_W-1:0]   slot_wdata [NUM_CH];
    logic [1:0]          slot_size  [NUM_CH];
    logic [NUM_CH-1:0]   slot_wr;

    logic [CH_W-1:0]     rr_ptr, cur_ch, gnt_ch, gnt_pos;
    logic [CH_W:0]       gnt_sum;
    logic [2*NUM_CH-1:0] elig_rot;
    logic [1:0]          cur_idx, cur_last, idx_d;
    logic                cur_wr, cur_io, gnt_vld, rd_inflight, on_last, abort;
    logic [ADDR_W-1:0]   cur_base, mem_addr_d;
    logic [DATA_W-1:0]   cur_wdata, asm_p1;
    logic [7:0]          mem_data_d;
    logic                mem_wr_d;

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return a[IO_SEL_LSB+1 -: 2] == 2'b11;
    endfunction

    // IO accesses always go out as a single byte regardless of requested size.
    function automatic logic [1:0] last_idx(input logic [1:0] size, input logic io);
        if (io || size == 2'd0) return 2'd0;
        if (size == 2'd1) return 2'd1;
        return 2'd3;
    endfunction

    function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w,
                                                   input logic [1:0] k,
                                                   input logic [7:0] b);
        logic [DATA_W-1:0] r;
        r = w;
        r[{k, 3'b000} +: 8] = b;
        return r;
    endfunction

    assign bus.out_req_ready = ~pending;

    always_comb begin
        rd_inflight = (state_q == S_ISSUE) && !cur_wr;
        on_last     = (state_q == S_ISSUE) && (cur_idx == cur_last);
        // An IO read already on the bus cannot be recalled, so flush lets it complete.
        abort = (state_q == S_ISSUE) && bus.in_flush && FLUSH_MASK[cur_ch] && !(cur_io && !cur_wr);

        accept   = '0;
        eligible = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            accept[c]   = bus.in_req_valid[c] && !pending[c] && !(bus.in_flush && FLUSH_MASK[c]);
            eligible[c] = pending[c] && !(bus.in_flush && FLUSH_MASK[c])
                          && !((state_q == S_ISSUE) && (cur_ch == CH_W'(c)));
            if (is_io(slot_addr[c]) && (rd_inflight || (slot_wr[c] && bus.in_io_buffer_full)))
                eligible[c] = 1'b0;
        end

        elig_rot = {eligible, eligible} >> rr_ptr;
        gnt_vld  = 1'b0;
        gnt_pos  = '0;
        if (!abort && (state_q == S_IDLE || on_last)) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (elig_rot[i]) begin
                    gnt_vld = 1'b1;
                    gnt_pos = CH_W'(i);
                end
            end
        end
        gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_pos};
        gnt_ch  = (gnt_sum >= N_CH) ? CH_W'(gnt_sum - N_CH) : gnt_sum[CH_W-1:0];

        state_d    = state_q;
        idx_d      = cur_idx;
        mem_addr_d = '0;
        mem_data_d = '0;
        mem_wr_d   = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else if (state_q == S_ISSUE && !on_last) begin
            idx_d      = cur_idx + 2'd1;
            mem_addr_d = cur_base + ADDR_W'(idx_d);
            mem_data_d = cur_wdata[{idx_d, 3'b000} +: 8];
            mem_wr_d   = cur_wr;
        end else if (gnt_vld) begin
            state_d    = S_ISSUE;
            idx_d      = 2'd0;
            mem_addr_d = slot_addr[gnt_ch];
            mem_data_d = slot_wdata[gnt_ch][7:0];
            mem_wr_d   = slot_wr[gnt_ch];
        end else begin
            state_d = S_IDLE;
        end

        pend_d = pending;
        if (on_last && !abort) pend_d[cur_ch] = 1'b0;
        if (bus.in_flush) pend_d = pend_d & ~FLUSH_MASK;
        pend_d = pend_d | accept;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q            <= S_IDLE;
            pending            <= '0;
            rr_ptr             <= '0;
            cur_ch             <= '0;
            cur_idx            <= '0;
            cur_last           <= '0;
            cur_wr             <= 1'b0;
            cur_io             <= 1'b0;
            bus.out_mem_addr   <= '0;
            bus.out_mem_data   <= '0;
            bus.out_mem_wr     <= 1'b0;
            bus.out_resp_valid <= '0;
            bus.out_resp_data  <= '0;
        end else if (bus.in_rdy) begin
            state_q            <= state_d;
            pending            <= pend_d;
            cur_idx            <= idx_d;
            bus.out_mem_addr   <= mem_addr_d;
            bus.out_mem_data   <= mem_data_d;
            bus.out_mem_wr     <= mem_wr_d;
            bus.out_resp_valid <= '0;
            if (rd_inflight && on_last && !abort) begin
                bus.out_resp_valid[cur_ch] <= 1'b1;
                bus.out_resp_data          <= put_byte(asm_p1, cur_idx, bus.in_mem_data);
            end
            if (gnt_vld) begin
                cur_ch   <= gnt_ch;
                cur_wr   <= slot_wr[gnt_ch];
                cur_io   <= is_io(slot_addr[gnt_ch]);
                cur_last <= last_idx(slot_size[gnt_ch], is_io(slot_addr[gnt_ch]));
                rr_ptr   <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
            end
        end
    end

    // Read bytes land in asm_p1 one edge after their address was driven.
    always_ff @(posedge in_clk) begin
        if (bus.in_rdy) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept[c]) begin
                    slot_addr[c]  <= bus.in_req_addr[c*ADDR_W +: ADDR_W];
                    slot_wdata[c] <= bus.in_req_wdata[c*DATA_W +: DATA_W];
                    slot_size[c]  <= bus.in_req_size[c*2 +: 2];
                    slot_wr[c]    <= bus.in_req_wr[c];
                end
            end
            if (gnt_vld) begin
                cur_base  <= slot_addr[gnt_ch];
                cur_wdata <= slot_wdata[gnt_ch];
                asm_p1    <= '0;
            end else if (rd_inflight) begin
                asm_p1 <= put_byte(asm_p1, cur_idx, bus.in_mem_data);
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter_mc.sv
// Directed bench for mem_arbiter_mc with a small byte RAM model on the bus.
module tb_mem_arbiter_mc;
    logic       clk = 1'b0;
    logic       rst;
    int         total = 0;
    int         bad = 0;
    logic [7:0] ram [4096];

    mem_arbiter_mc_if #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter_mc #(
        .NUM_CH(3), .ADDR_W(32), .DATA_W(32), .IO_SEL_LSB(16), .FLUSH_MASK(3'b011)
    ) dut (
        .in_clk(clk),
        .in_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.in_mem_data = ram[bus.out_mem_addr[11:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int c, input logic [31:0] a, input logic wr,
                       input logic [1:0] sz, input logic [31:0] wd);
        bus.in_req_addr[c*32 +: 32]  = a;
        bus.in_req_wr[c]             = wr;
        bus.in_req_size[c*2 +: 2]    = sz;
        bus.in_req_wdata[c*32 +: 32] = wd;
        bus.in_req_valid[c]          = 1'b1;
    endtask

    task automatic exp_bus(input string tag, input logic [31:0] a, input logic wr);
        chk({tag, "_addr"}, bus.out_mem_addr, a);
        chk({tag, "_wr"}, {31'd0, bus.out_mem_wr}, {31'd0, wr});
    endtask

    task automatic exp_resp(input string tag, input logic [2:0] v, input logic [31:0] d);
        chk({tag, "_rvld"}, {29'd0, bus.out_resp_valid}, {29'd0, v});
        if (v != 3'b000) chk({tag, "_rdata"}, bus.out_resp_data, d);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst                   = 1'b1;
        bus.in_rdy            = 1'b1;
        bus.in_flush          = 1'b0;
        bus.in_io_buffer_full = 1'b0;
        bus.in_req_valid      = '0;
        bus.in_req_addr       = '0;
        bus.in_req_wr         = '0;
        bus.in_req_size       = '0;
        bus.in_req_wdata      = '0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h104] = 8'h55; ram[12'h105] = 8'h66; ram[12'h106] = 8'h77; ram[12'h107] = 8'h88;
        ram[12'h110] = 8'hAA; ram[12'h120] = 8'hBB; ram[12'h130] = 8'hCC;
        ram[12'h140] = 8'hDD; ram[12'h150] = 8'hEE;
        ram[12'h000] = 8'h5A; ram[12'h008] = 8'hC3;

        #12;
        exp_bus("rst", 32'h0, 1'b0);
        chk("rst_wdata", {24'd0, bus.out_mem_data}, 32'h0);
        exp_resp("rst", 3'b000, 32'h0);
        chk("rst_ready", {29'd0, bus.out_req_ready}, 32'h7);
        rst = 1'b0;
        tick();

        // Word load with a two-cycle rdy stall in the middle
        req(0, 32'h100, 1'b0, 2'd2, 32'h0);
        tick();
        bus.in_req_valid = '0;
        chk("t1_busy", {29'd0, bus.out_req_ready}, 32'h6);
        tick(); exp_bus("t1_b0", 32'h100, 1'b0);
        tick(); exp_bus("t1_b1", 32'h101, 1'b0);
        bus.in_rdy = 1'b0;
        tick(); tick();
        exp_bus("t1_hold", 32'h101, 1'b0);
        bus.in_rdy = 1'b1;
        tick(); exp_bus("t1_b2", 32'h102, 1'b0);
        tick(); exp_bus("t1_b3", 32'h103, 1'b0);
        exp_resp("t1_early", 3'b000, 32'h0);
        tick(); exp_resp("t1_resp", 3'b001, 32'h44332211);
        exp_bus("t1_idle", 32'h0, 1'b0);
        chk("t1_ready", {29'd0, bus.out_req_ready}, 32'h7);
        tick(); exp_resp("t1_pulse", 3'b000, 32'h0);

        // Three simultaneous byte loads, then a rr fairness re-request
        pulse_reset();
        req(0, 32'h110, 1'b0, 2'd0, 32'h0);
        req(1, 32'h120, 1'b0, 2'd0, 32'h0);
        req(2, 32'h130, 1'b0, 2'd0, 32'h0);
        tick();
        bus.in_req_valid = '0;
        chk("t2_busy", {29'd0, bus.out_req_ready}, 32'h0);
        tick(); exp_bus("t2_g0", 32'h110, 1'b0);
        tick(); exp_bus("t2_g1", 32'h120, 1'b0); exp_resp("t2_r0", 3'b001, 32'hAA);
        tick(); exp_bus("t2_g2", 32'h130, 1'b0); exp_resp("t2_r1", 3'b010, 32'hBB);
        tick(); exp_bus("t2_idle", 32'h0, 1'b0); exp_resp("t2_r2", 3'b100, 32'hCC);
        req(0, 32'h140, 1'b0, 2'd0, 32'h0);
        req(2, 32'h150, 1'b0, 2'd0, 32'h0);
        tick();
        bus.in_req_valid = '0;
        tick(); exp_bus("t2_rr0", 32'h140, 1'b0);
        tick(); exp_bus("t2_rr2", 32'h150, 1'b0); exp_resp("t2_rr_r0", 3'b001, 32'hDD);
        tick(); exp_resp("t2_rr_r2", 3'b100, 32'hEE);

        // Half-word store on ch1
        req(1, 32'h200, 1'b1, 2'd1, 32'hAABBCCDD);
        tick();
        bus.in_req_valid = '0;
        tick(); exp_bus("t3_w0", 32'h200, 1'b1);
        chk("t3_d0", {24'd0, bus.out_mem_data}, 32'hDD);
        tick(); exp_bus("t3_w1", 32'h201, 1'b1);
        chk("t3_d1", {24'd0, bus.out_mem_data}, 32'hCC);
        chk("t3_busy", {31'd0, bus.out_req_ready[1]}, 32'h0);
        tick(); exp_bus("t3_idle", 32'h0, 1'b0);
        chk("t3_ready", {31'd0, bus.out_req_ready[1]}, 32'h1);
        exp_resp("t3_noresp", 3'b000, 32'h0);

        // IO load arrives while a word read is in flight
        req(0, 32'h104, 1'b0, 2'd2, 32'h0);
        tick();
        bus.in_req_valid = '0;
        req(2, 32'h30000, 1'b0, 2'd2, 32'h0);
        tick(); exp_bus("t4_b0", 32'h104, 1'b0);
        bus.in_req_valid = '0;
        tick(); tick();
        tick(); exp_bus("t4_b3", 32'h107, 1'b0);
        tick(); exp_bus("t4_wait", 32'h0, 1'b0); exp_resp("t4_r0", 3'b001, 32'h88776655);
        tick(); exp_bus("t4_io", 32'h30000, 1'b0);
        tick(); exp_bus("t4_single", 32'h0, 1'b0); exp_resp("t4_rio", 3'b100, 32'h5A);

        // IO store held off by a full IO write buffer
        bus.in_io_buffer_full = 1'b1;
        req(1, 32'h30004, 1'b1, 2'd0, 32'h77);
        tick();
        bus.in_req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t5_held", {31'd0, bus.out_mem_wr}, 32'h0);
        end
        bus.in_io_buffer_full = 1'b0;
        tick(); exp_bus("t5_wr", 32'h30004, 1'b1);
        chk("t5_data", {24'd0, bus.out_mem_data}, 32'h77);
        tick(); chk("t5_done", {31'd0, bus.out_mem_wr}, 32'h0);
        chk("t5_ready", {31'd0, bus.out_req_ready[1]}, 32'h1);

        // Flush aborts ch1 word load; ch2 store survives; masked ch0 not accepted
        req(1, 32'h300, 1'b0, 2'd2, 32'h0);
        tick();
        bus.in_req_valid = '0;
        req(2, 32'h400, 1'b1, 2'd1, 32'h1234);
        tick(); exp_bus("t6_b0", 32'h300, 1'b0);
        bus.in_req_valid = '0;
        tick();
        tick(); exp_bus("t6_b2", 32'h302, 1'b0);
        bus.in_flush = 1'b1;
        req(0, 32'h140, 1'b0, 2'd0, 32'h0);
        tick();
        bus.in_flush = 1'b0;
        bus.in_req_valid = '0;
        exp_bus("t6_idle", 32'h0, 1'b0);
        chk("t6_ready", {29'd0, bus.out_req_ready}, 32'h3);
        tick(); exp_bus("t6_s0", 32'h400, 1'b1);
        chk("t6_sd0", {24'd0, bus.out_mem_data}, 32'h34);
        exp_resp("t6_noresp", 3'b000, 32'h0);
        tick(); exp_bus("t6_s1", 32'h401, 1'b1);
        chk("t6_sd1", {24'd0, bus.out_mem_data}, 32'h12);
        tick(); exp_bus("t6_end", 32'h0, 1'b0);
        chk("t6_ready2", {29'd0, bus.out_req_ready}, 32'h7);

        // An issued IO read still responds through a flush
        req(0, 32'h30008, 1'b0, 2'd0, 32'h0);
        tick();
        bus.in_req_valid = '0;
        tick(); exp_bus("t7_io", 32'h30008, 1'b0);
        bus.in_flush = 1'b1;
        tick();
        bus.in_flush = 1'b0;
        exp_resp("t7_resp", 3'b001, 32'hC3);

        // Asynchronous reset in the middle of a word store
        req(2, 32'h500, 1'b1, 2'd2, 32'hCAFEBABE);
        tick();
        bus.in_req_valid = '0;
        tick(); exp_bus("t8_s0", 32'h500, 1'b1);
        tick(); chk("t8_d1", {24'd0, bus.out_mem_data}, 32'hBA);
        rst = 1'b1;
        #1;
        exp_bus("t8_rst", 32'h0, 1'b0);
        chk("t8_rst_data", {24'd0, bus.out_mem_data}, 32'h0);
        chk("t8_rst_ready", {29'd0, bus.out_req_ready}, 32'h7);
        tick();
        rst = 1'b0;
        tick(); exp_bus("t8_after", 32'h0, 1'b0);
        exp_resp("t8_after", 3'b000, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
